// File: rtl/buzzer_tone_gen.sv
// -----------------------------------------------------------------------------
// buzzer_tone_gen
// Turns the music player's 8-bit tone index into a square wave for a passive
// buzzer. Each valid index maps to a half-period cycle count that is fixed at
// elaboration. Tone changes and rests only take effect at half-period
// boundaries, so the buzzer never sees a runt pulse.
//
// Ports:
//   sys_clk      in   1  system clock
//   sys_rst      in   1  asynchronous, active-high reset
//   en           in   1  play enable (asynchronous, synchronised here)
//   music_tone   in   8  tone index: 0 = rest, 1..MAX_TONE = notes, above = rest
//   buzzer       out  1  square-wave drive
//   tone_active  out  1  high while the tone engine is running
//   period_tick  out  1  one-cycle pulse on every buzzer 0->1 transition
// -----------------------------------------------------------------------------
module buzzer_tone_gen #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int CNT_W    = 20,
    parameter int MAX_TONE = 21
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       en,
    input  logic [7:0] music_tone,
    output logic       buzzer,
    output logic       tone_active,
    output logic       period_tick
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [7:0]       MAX_IDX = 8'(MAX_TONE);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Half-period lookup; every entry folds to a constant at elaboration.
    function automatic logic [CNT_W-1:0] half_of(input logic [7:0] idx);
        case (idx)
            8'd1:    half_of = CNT_W'(CLK_FREQ / (2 * 262));
            8'd2:    half_of = CNT_W'(CLK_FREQ / (2 * 294));
            8'd3:    half_of = CNT_W'(CLK_FREQ / (2 * 330));
            8'd4:    half_of = CNT_W'(CLK_FREQ / (2 * 349));
            8'd5:    half_of = CNT_W'(CLK_FREQ / (2 * 392));
            8'd6:    half_of = CNT_W'(CLK_FREQ / (2 * 440));
            8'd7:    half_of = CNT_W'(CLK_FREQ / (2 * 494));
            8'd8:    half_of = CNT_W'(CLK_FREQ / (2 * 523));
            8'd9:    half_of = CNT_W'(CLK_FREQ / (2 * 587));
            8'd10:   half_of = CNT_W'(CLK_FREQ / (2 * 659));
            8'd11:   half_of = CNT_W'(CLK_FREQ / (2 * 698));
            8'd12:   half_of = CNT_W'(CLK_FREQ / (2 * 784));
            8'd13:   half_of = CNT_W'(CLK_FREQ / (2 * 880));
            8'd14:   half_of = CNT_W'(CLK_FREQ / (2 * 988));
            8'd15:   half_of = CNT_W'(CLK_FREQ / (2 * 1047));
            8'd16:   half_of = CNT_W'(CLK_FREQ / (2 * 1175));
            8'd17:   half_of = CNT_W'(CLK_FREQ / (2 * 1319));
            8'd18:   half_of = CNT_W'(CLK_FREQ / (2 * 1397));
            8'd19:   half_of = CNT_W'(CLK_FREQ / (2 * 1568));
            8'd20:   half_of = CNT_W'(CLK_FREQ / (2 * 1760));
            8'd21:   half_of = CNT_W'(CLK_FREQ / (2 * 1976));
            // Never selected for a load; a count of one keeps the boundary compare sane.
            default: half_of = CNT_ONE;
        endcase
    endfunction

    logic             r_en_m;
    logic             r_en_s;
    logic [7:0]       r_tone_s1;
    logic [7:0]       r_tone_s2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half_q;
    logic [7:0]       r_tone_q;
    logic             r_buzzer;
    logic             r_tick;
    logic             r_active;

    logic             w_stable;
    logic             w_valid_idx;
    logic             w_req_play;
    logic             w_req_rest;
    logic             w_boundary;
    state_t           w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] w_half_nx;
    logic [7:0]       w_tone_nx;
    logic             w_buzz_nx;
    logic             w_tick_nx;

    // Two-flop synchroniser for en and two-stage capture of the tone index.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_en_m    <= 1'b0;
            r_en_s    <= 1'b0;
            r_tone_s1 <= 8'd0;
            r_tone_s2 <= 8'd0;
        end else begin
            r_en_m    <= en;
            r_en_s    <= r_en_m;
            r_tone_s1 <= music_tone;
            r_tone_s2 <= r_tone_s1;
        end
    end

    // A tone is only trusted once both capture stages agree, which filters
    // multi-bit skew from the slower music-player domain. Dropping en is a
    // rest even while the index is unsettled.
    assign w_stable    = (r_tone_s1 == r_tone_s2);
    assign w_valid_idx = (r_tone_s2 >= 8'd1) && (r_tone_s2 <= MAX_IDX);
    assign w_req_play  = r_en_s & w_stable & w_valid_idx;
    assign w_req_rest  = ~r_en_s | (w_stable & ~w_valid_idx);
    assign w_boundary  = (r_cnt == (r_half_q - CNT_ONE));

    // Next-state and next-output logic for the tone engine.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_half_nx  = r_half_q;
        w_tone_nx  = r_tone_q;
        w_buzz_nx  = r_buzzer;
        w_tick_nx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_buzz_nx = 1'b0;
                w_cnt_nx  = '0;
                if (w_req_play) begin
                    w_tone_nx  = r_tone_s2;
                    w_half_nx  = half_of(r_tone_s2);
                    w_buzz_nx  = 1'b1;
                    w_tick_nx  = 1'b1;
                    w_state_nx = ST_RUN;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_boundary) begin
                    w_cnt_nx = '0;
                    if (w_req_rest) begin
                        // Stop from either level so a high phase is never stretched.
                        w_buzz_nx  = 1'b0;
                        w_state_nx = ST_IDLE;
                    end else if (w_req_play && (r_tone_s2 != r_tone_q)) begin
                        w_tone_nx = r_tone_s2;
                        w_half_nx = half_of(r_tone_s2);
                        w_buzz_nx = ~r_buzzer;
                        w_tick_nx = ~r_buzzer;
                    end else begin
                        // Same tone or unsettled index: keep the waveform running.
                        w_buzz_nx = ~r_buzzer;
                        w_tick_nx = ~r_buzzer;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
                w_buzz_nx  = 1'b0;
            end
        endcase
    end

    // Tone engine state and registered outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_half_q <= '0;
            r_tone_q <= 8'd0;
            r_buzzer <= 1'b0;
            r_tick   <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_half_q <= w_half_nx;
            r_tone_q <= w_tone_nx;
            r_buzzer <= w_buzz_nx;
            r_tick   <= w_tick_nx;
            r_active <= (w_state_nx == ST_RUN);
        end
    end

    assign buzzer      = r_buzzer;
    assign tone_active = r_active;
    assign period_tick = r_tick;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// -----------------------------------------------------------------------------
// Directed bench for buzzer_tone_gen. CLK_FREQ is scaled down to 100 kHz so
// whole waveforms fit in a short run. Hand-computed half periods
// (100000 / (2*f), integer division):
//   tone 1  (262 Hz)  -> 190
//   tone 6  (440 Hz)  -> 113
//   tone 8  (523 Hz)  -> 95
//   tone 13 (880 Hz)  -> 56
//   tone 21 (1976 Hz) -> 25
// -----------------------------------------------------------------------------
module tb_buzzer_tone_gen;

    localparam int H1  = 190;
    localparam int H6  = 113;
    localparam int H8  = 95;
    localparam int H13 = 56;
    localparam int H21 = 25;

    logic       sys_clk;
    logic       sys_rst;
    logic       en;
    logic [7:0] music_tone;
    logic       buzzer;
    logic       tone_active;
    logic       period_tick;

    int n_assert;
    int n_fail;
    int n;

    buzzer_tone_gen #(
        .CLK_FREQ (100_000),
        .CNT_W    (20),
        .MAX_TONE (21)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .en          (en),
        .music_tone  (music_tone),
        .buzzer      (buzzer),
        .tone_active (tone_active),
        .period_tick (period_tick)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input int observed, input int expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Count falling edges until buzzer reaches lvl, giving up after bound.
    task automatic wait_level(input logic lvl, input int bound, output int cnt);
        cnt = 0;
        while (buzzer !== lvl && cnt < bound) begin
            @(negedge sys_clk);
            cnt++;
        end
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        sys_rst    = 1'b1;
        en         = 1'b1;
        music_tone = 8'd6;

        // Reset held with a valid request pending.
        repeat (4) @(negedge sys_clk);
        chk("rst_buzzer", int'(buzzer), 0);
        chk("rst_active", int'(tone_active), 0);
        chk("rst_tick", int'(period_tick), 0);

        // Release: first rise three edges later, then 440 Hz.
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("lat_pre_rise", int'(buzzer), 0);
        @(negedge sys_clk);
        chk("lat_rise", int'(buzzer), 1);
        chk("lat_tick", int'(period_tick), 1);
        chk("lat_active", int'(tone_active), 1);
        @(negedge sys_clk);
        chk("tick_one_cycle", int'(period_tick), 0);
        wait_level(1'b0, 1000, n);
        chk("t6_high", n + 1, H6);
        chk("fall_no_tick", int'(period_tick), 0);
        wait_level(1'b1, 1000, n);
        chk("t6_low", n, H6);
        chk("t6_tick", int'(period_tick), 1);

        // Change to tone 13 mid-high: current high finishes at full length.
        repeat (10) @(negedge sys_clk);
        music_tone = 8'd13;
        wait_level(1'b0, 1000, n);
        chk("t6_to_13_high", n, H6 - 10);
        wait_level(1'b1, 1000, n);
        chk("t13_low", n, H13);
        wait_level(1'b0, 1000, n);
        chk("t13_high", n, H13);

        // Tone 8 takes over at the next boundary; rest during high phase.
        music_tone = 8'd8;
        wait_level(1'b1, 1000, n);
        chk("t13_low_before_8", n, H13);
        repeat (5) @(negedge sys_clk);
        music_tone = 8'd0;
        wait_level(1'b0, 1000, n);
        chk("t8_rest_fall", n, H8 - 5);
        chk("t8_rest_active", int'(tone_active), 0);
        wait_level(1'b1, 300, n);
        chk("t8_rest_silent", n, 300);

        // Same with an out-of-range index.
        music_tone = 8'd8;
        wait_level(1'b1, 1000, n);
        chk("t8_restart_lat", n, 3);
        repeat (5) @(negedge sys_clk);
        music_tone = 8'd25;
        wait_level(1'b0, 1000, n);
        chk("t25_rest_fall", n, H8 - 5);
        chk("t25_rest_active", int'(tone_active), 0);
        wait_level(1'b1, 300, n);
        chk("t25_rest_silent", n, 300);

        // Tone 1, en dropped mid-high, then re-enabled.
        music_tone = 8'd1;
        wait_level(1'b1, 1000, n);
        chk("t1_start_lat", n, 3);
        repeat (20) @(negedge sys_clk);
        en = 1'b0;
        wait_level(1'b0, 1000, n);
        chk("en_off_fall", n, H1 - 20);
        chk("en_off_active", int'(tone_active), 0);
        wait_level(1'b1, 300, n);
        chk("en_off_silent", n, 300);
        en = 1'b1;
        wait_level(1'b1, 1000, n);
        chk("en_on_lat", n, 3);
        wait_level(1'b0, 1000, n);
        chk("en_on_high", n, H1);
        music_tone = 8'd0;
        repeat (200) @(negedge sys_clk);
        chk("t1_idle_active", int'(tone_active), 0);
        chk("t1_idle_buzzer", int'(buzzer), 0);

        // One-cycle glitch 6 -> 31 -> 6 while idle: stable 6 is what loads.
        music_tone = 8'd6;
        @(negedge sys_clk);
        music_tone = 8'd31;
        @(negedge sys_clk);
        music_tone = 8'd6;
        wait_level(1'b1, 1000, n);
        chk("glitch_idle_lat", n, 3);
        // Glitch straddling the boundary while running must not stop the tone.
        repeat (110) @(negedge sys_clk);
        music_tone = 8'd31;
        @(negedge sys_clk);
        music_tone = 8'd6;
        wait_level(1'b0, 1000, n);
        chk("glitch_run_fall", n, H6 - 111);
        chk("glitch_run_active", int'(tone_active), 1);
        wait_level(1'b1, 1000, n);
        chk("glitch_run_low", n, H6);

        // Tone 21, then asynchronous reset mid-phase.
        music_tone = 8'd21;
        wait_level(1'b0, 1000, n);
        chk("t6_to_21_high", n, H6);
        wait_level(1'b1, 1000, n);
        chk("t21_low", n, H21);
        chk("t21_tick", int'(period_tick), 1);
        repeat (10) @(negedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        chk("async_rst_buzzer", int'(buzzer), 0);
        chk("async_rst_active", int'(tone_active), 0);
        chk("async_rst_tick", int'(period_tick), 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        wait_level(1'b1, 1000, n);
        chk("post_rst_lat", n, 3);
        wait_level(1'b0, 1000, n);
        chk("post_rst_high", n, H21);
        wait_level(1'b1, 1000, n);
        chk("post_rst_low", n, H21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
